// File: rtl/nonce_search_ctrl_if.sv
// Handshake between the nonce search controller (master) and the micro-hash core (slave).
interface nonce_search_ctrl_if #(
  parameter int BYTE = 8
);
  logic                hash_start;
  logic [BYTE*16-1:0]  hash_block;
  logic                hash_done;
  logic [BYTE*3-1:0]   hash_in;

  modport master (output hash_start, hash_block, input hash_done, hash_in);
  modport slave  (input hash_start, hash_block, output hash_done, hash_in);
endinterface

// File: rtl/nonce_search_ctrl.sv
// Nonce search sequencer: appends a nonce to a latched header, issues blocks to the
// hash core one at a time and stops on the first hash whose H0 and H1 are below target.
//
// state   | meaning
// IDLE    | just out of reset
// LOAD    | latch header and target
// ISSUE   | hash_start pulse, block valid
// WAIT    | waiting for hash_done
// CHECK   | compare latched hash to target
// FOUND   | match found, held until reset
// EXHAUST | nonce space ended (or target 0), held until reset
module nonce_search_ctrl #(
  parameter int                 BYTE        = 8,
  parameter int                 NONCE_W     = 32,
  parameter logic [NONCE_W-1:0] NONCE_START = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BYTE*12-1:0]   data_in,
  input  logic [BYTE-1:0]      target,
  nonce_search_ctrl_if.master  hash_if,
  output logic                 finished,
  output logic                 exhausted,
  output logic [NONCE_W-1:0]   nonce_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_FOUND, S_EXHAUST
  } state_t;

  localparam logic [NONCE_W-1:0] NONCE_LAST = '1;
  localparam logic [NONCE_W-1:0] NONCE_ONE  = {{(NONCE_W-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                next_state;
  logic [BYTE*12-1:0]    header_reg;
  logic [BYTE-1:0]       target_reg;
  logic [2*BYTE-1:0]     hash_reg;     // {H0, H1}; H2 never takes part in the compare
  logic [NONCE_W-1:0]    nonce;
  logic [NONCE_W-1:0]    nonce_inc;
  logic [BYTE*16-1:0]    block_reg;
  logic                  hash_match;
  logic                  nonce_last;

  assign nonce_inc  = nonce + NONCE_ONE;
  assign nonce_last = (nonce == NONCE_LAST);
  assign hash_match = (hash_reg[2*BYTE-1:BYTE] < target_reg) && (hash_reg[BYTE-1:0] < target_reg);
  assign hash_if.hash_block = block_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    next_state = S_LOAD;
      S_LOAD:    next_state = (target == '0) ? S_EXHAUST : S_ISSUE;
      S_ISSUE:   next_state = S_WAIT;
      S_WAIT:    if (hash_if.hash_done) next_state = S_CHECK;
      S_CHECK: begin
        if (hash_match)      next_state = S_FOUND;
        else if (nonce_last) next_state = S_EXHAUST;
        else                 next_state = S_ISSUE;
      end
      default:   next_state = state;
    endcase
  end

  always_comb begin
    hash_if.hash_start = (state == S_ISSUE);
    finished           = (state == S_FOUND);
    exhausted          = (state == S_EXHAUST);
  end

  // The block is loaded on the edge entering ISSUE so it is already valid with hash_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      header_reg <= '0;
      target_reg <= '0;
      hash_reg   <= '0;
      nonce      <= NONCE_START;
      nonce_out  <= '0;
      block_reg  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          header_reg <= data_in;
          target_reg <= target;
          if (target == '0) nonce_out <= NONCE_START;
          else              block_reg <= {data_in, nonce};
        end
        S_WAIT: begin
          if (hash_if.hash_done) hash_reg <= hash_if.hash_in[BYTE*3-1:BYTE];
        end
        S_CHECK: begin
          if (hash_match || nonce_last) begin
            nonce_out <= nonce;
          end else begin
            nonce     <= nonce_inc;
            block_reg <= {header_reg, nonce_inc};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
